shift_data_path: RTL and testbench

SHIFT_DATA_PATH -- requirements
Module: shift_data_path

---
 rtl/shift_data_path_if.sv | 42 ++++
 rtl/shift_data_path.sv | 127 ++++++++++++
 tb/tb_shift_data_path.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_data_path_if.sv
// -----------------------------------------------------------------------------
// shift_data_path_if
//   Bundles the write/flush controls, the edge threshold and the observable
//   state of shift_data_path into one interface.
//
//   Signals
//     write_en   1   shift data_in into the store this cycle
//     data_in    32  four 8-bit pixels, byte k = bits [8k+7:8k]
//     flush      1   synchronous clear of store and fill count
//     threshold  16  unsigned edge threshold
//     w0..w5     32  store contents, w0 newest, w5 oldest
//     full       1   six words held since reset/flush
//     edges      32  four Sobel results, one byte each
//
//   Modports
//     master  drives the controls and observes the outputs (stimulus side)
//     slave   the shift_data_path side
// -----------------------------------------------------------------------------
interface shift_data_path_if;
    logic        write_en;
    logic [31:0] data_in;
    logic        flush;
    logic [15:0] threshold;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    logic [31:0] w4;
    logic [31:0] w5;
    logic        full;
    logic [31:0] edges;

    modport master (
        output write_en, data_in, flush, threshold,
        input  w0, w1, w2, w3, w4, w5, full, edges
    );

    modport slave (
        input  write_en, data_in, flush, threshold,
        output w0, w1, w2, w3, w4, w5, full, edges
    );
endinterface

// File: rtl/shift_data_path.sv
// -----------------------------------------------------------------------------
// shift_data_path
//   Six-word pixel store forming a 3-row x 8-column window, with four Sobel
//   edge detectors on the middle row (columns 2..5).
//
//   Ports
//     clk    rising-edge clock for all state
//     rst_n  asynchronous active-low reset (clears store, count and full)
//     bus    shift_data_path_if.slave: write_en, data_in, flush, threshold in;
//            w0..w5, full, edges out
//
//   Window rows (column 0 = byte 0 of the older word of each pair):
//     top = w5 bytes 0-3, w4 bytes 0-3
//     mid = w3, w2
//     bot = w1, w0
//
//   Configuration macro SDP_MAGNITUDE_OUT_EN
//     undefined: edges byte = 8'hFF when |Gx|+|Gy| > threshold, else 8'h00
//     defined:   edges byte = min(|Gx|+|Gy|, 255); threshold ignored
//   In both builds edges reads zero until the store is full.
// -----------------------------------------------------------------------------
module shift_data_path (
    input  logic              clk,
    input  logic              rst_n,
    shift_data_path_if.slave  bus
);

    // store_q[0] is the newest word (w0), store_q[5] the oldest (w5).
    logic [5:0][31:0] store_q;
    logic [2:0]       count_q;
    logic             full_q;

    // Each row as one 64-bit vector so that column c is simply bits [8c+7:8c].
    logic [63:0] row_top;
    logic [63:0] row_mid;
    logic [63:0] row_bot;
    logic [31:0] edges_raw;

    // -------------------------------------------------------------------------
    // Store, fill count and full flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the store is only six words, and reset must make edges/full
        // observably zero at once, so every storage bit is reset here rather
        // than left to power-up values as a large RAM would be.
        if (!rst_n) begin
            store_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else if (bus.flush) begin
            // flush outranks a simultaneous write
            store_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else if (bus.write_en) begin
            // NOTE: non-blocking assignments make every register read the
            // pre-edge value, which is exactly the shift-register behaviour.
            store_q <= {store_q[4:0], bus.data_in};
            if (count_q != 3'd6) begin
                count_q <= count_q + 3'd1;
            end
            // full becomes 1 on the edge that takes the 6th write and stays 1
            full_q <= (count_q >= 3'd5);
        end
    end

    // -------------------------------------------------------------------------
    // Sobel magnitude from the eight neighbours (centre pixel has weight 0).
    // Positive and negative halves are kept unsigned so |G| is a single
    // compare-and-subtract; each half is at most 1020 and fits 10 bits.
    // -------------------------------------------------------------------------
    function automatic logic [10:0] sobel_mag(
        input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
        input logic [7:0] m0,                       input logic [7:0] m2,
        input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2
    );
        logic [9:0] gx_pos, gx_neg, gy_pos, gy_neg;
        logic [9:0] ax, ay;
        gx_pos = {2'b0, t2} + {1'b0, m2, 1'b0} + {2'b0, b2};
        gx_neg = {2'b0, t0} + {1'b0, m0, 1'b0} + {2'b0, b0};
        gy_pos = {2'b0, b0} + {1'b0, b1, 1'b0} + {2'b0, b2};
        gy_neg = {2'b0, t0} + {1'b0, t1, 1'b0} + {2'b0, t2};
        ax = (gx_pos >= gx_neg) ? (gx_pos - gx_neg) : (gx_neg - gx_pos);
        ay = (gy_pos >= gy_neg) ? (gy_pos - gy_neg) : (gy_neg - gy_pos);
        return {1'b0, ax} + {1'b0, ay};
    endfunction

    function automatic logic [7:0] edge_byte(input logic [10:0] mag,
                                             input logic [15:0] thr);
`ifdef SDP_MAGNITUDE_OUT_EN
        return (mag > 11'd255) ? 8'hFF : mag[7:0];
`else
        return ({5'b0, mag} > thr) ? 8'hFF : 8'h00;
`endif
    endfunction

    assign row_top = {store_q[4], store_q[5]};
    assign row_mid = {store_q[2], store_q[3]};
    assign row_bot = {store_q[0], store_q[1]};

    always_comb begin
        // NOTE: default first so no path through this block leaves edges_raw
        // unassigned, which would otherwise infer a latch.
        edges_raw = '0;
        for (int k = 0; k < 4; k++) begin
            // output byte k is centred on column k+2, neighbours k+1 .. k+3
            edges_raw[8*k +: 8] = edge_byte(
                sobel_mag(row_top[8*(k+1) +: 8], row_top[8*(k+2) +: 8], row_top[8*(k+3) +: 8],
                          row_mid[8*(k+1) +: 8],                        row_mid[8*(k+3) +: 8],
                          row_bot[8*(k+1) +: 8], row_bot[8*(k+2) +: 8], row_bot[8*(k+3) +: 8]),
                bus.threshold);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.w0    = store_q[0];
    assign bus.w1    = store_q[1];
    assign bus.w2    = store_q[2];
    assign bus.w3    = store_q[3];
    assign bus.w4    = store_q[4];
    assign bus.w5    = store_q[5];
    assign bus.full  = full_q;
    assign bus.edges = full_q ? edges_raw : 32'h0000_0000;

endmodule

// File: tb/tb_shift_data_path.sv
// -----------------------------------------------------------------------------
// tb_shift_data_path
//   Scoreboarded bench for shift_data_path. Each driven cycle pushes the
//   expected store/full/edges into a queue; a monitor pops and compares one
//   entry per cycle just after the clock edge. Expected values come from a
//   word-history queue and a pixel-grid Sobel model. Directed checks cover
//   reset, fill, flat image, vertical edge, overflow and flush-vs-write.
// -----------------------------------------------------------------------------
module tb_shift_data_path;

    logic clk = 1'b0;
    logic rst_n;

    shift_data_path_if bus ();

    shift_data_path dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef SDP_MAGNITUDE_OUT_EN
    localparam logic [31:0] VERT_HIGH_THR = 32'h00FF_FF00;
`else
    localparam logic [31:0] VERT_HIGH_THR = 32'h0000_0000;
`endif

    typedef struct packed {
        logic [5:0][31:0] w;
        logic             full;
        logic [31:0]      edges;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] hist[$];   // written words, newest at index 0
    int          fill_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    function automatic logic [5:0][31:0] model_words();
        logic [5:0][31:0] w;
        w = '0;
        for (int i = 0; i < hist.size() && i < 6; i++) w[i] = hist[i];
        return w;
    endfunction

    // Pixel at window row r (0 top .. 2 bottom), column c (0..7).
    function automatic int pix(input logic [5:0][31:0] w, input int r, input int c);
        int idx;
        idx = 5 - 2 * r - (c / 4);
        return int'((w[idx] >> (8 * (c % 4))) & 32'hFF);
    endfunction

    function automatic logic [31:0] model_edges(input logic [5:0][31:0] w, input int thr);
        logic [31:0] res;
        int gx, gy, mag, b;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            int c;
            c  = k + 2;
            gx = (pix(w,0,c+1) + 2*pix(w,1,c+1) + pix(w,2,c+1))
               - (pix(w,0,c-1) + 2*pix(w,1,c-1) + pix(w,2,c-1));
            gy = (pix(w,2,c-1) + 2*pix(w,2,c) + pix(w,2,c+1))
               - (pix(w,0,c-1) + 2*pix(w,0,c) + pix(w,0,c+1));
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SDP_MAGNITUDE_OUT_EN
            b = (mag > 255) ? 255 : mag;
`else
            b = (mag > thr) ? 255 : 0;
`endif
            res = res | (32'(b) << (8 * k));
        end
        return res;
    endfunction

    // ------------------------------------------------------------- stimulus
    task automatic do_op(input bit we, input bit fl, input logic [31:0] d, input logic [15:0] thr);
        exp_t e;
        @(negedge clk);
        bus.write_en  = we;
        bus.flush     = fl;
        bus.data_in   = d;
        bus.threshold = thr;
        if (fl) begin
            hist.delete();
            fill_cnt = 0;
        end else if (we) begin
            hist.push_front(d);
            if (hist.size() > 6) void'(hist.pop_back());
            if (fill_cnt < 6) fill_cnt++;
        end
        e.w     = model_words();
        e.full  = (fill_cnt == 6);
        e.edges = e.full ? model_edges(e.w, int'(thr)) : 32'h0;
        sb_q.push_back(e);
    endtask

    // Wait until the last driven cycle has been clocked in and settled.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_w0"}, bus.w0, 32'h0);
        check({tag, "_w1"}, bus.w1, 32'h0);
        check({tag, "_w2"}, bus.w2, 32'h0);
        check({tag, "_w3"}, bus.w3, 32'h0);
        check({tag, "_w4"}, bus.w4, 32'h0);
        check({tag, "_w5"}, bus.w5, 32'h0);
        check({tag, "_full"}, {31'b0, bus.full}, 32'h0);
        check({tag, "_edges"}, bus.edges, 32'h0);
    endtask

    // Asynchronous reset pulse between clock edges; outputs checked before
    // any further edge arrives.
    task automatic mid_reset();
        settle();
        bus.write_en = 1'b0;
        bus.flush    = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        hist.delete();
        fill_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] v;
        if ($urandom_range(0, 1) == 0) begin
            v = $urandom;
        end else begin
            v = '0;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 1) == 1) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic random_ops(input int n);
        int r;
        logic [15:0] thr;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0:       thr = 16'd0;
                1:       thr = 16'hFFFF;
                default: thr = 16'($urandom_range(0, 2100));
            endcase
            do_op(r < 65, r >= 95, rand_word(), thr);
        end
    endtask

    // -------------------------------------------------------------- monitor
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("sb_w0", bus.w0, mon_e.w[0]);
            check("sb_w1", bus.w1, mon_e.w[1]);
            check("sb_w2", bus.w2, mon_e.w[2]);
            check("sb_w3", bus.w3, mon_e.w[3]);
            check("sb_w4", bus.w4, mon_e.w[4]);
            check("sb_w5", bus.w5, mon_e.w[5]);
            check("sb_full", {31'b0, bus.full}, {31'b0, mon_e.full});
            check("sb_edges", bus.edges, mon_e.edges);
        end
    end

    // ----------------------------------------------------------------- main
    initial begin
        fill_cnt      = 0;
        bus.write_en  = 1'b0;
        bus.flush     = 1'b0;
        bus.data_in   = '0;
        bus.threshold = '0;
        rst_n         = 1'b1;
        #2 rst_n = 1'b0;
        #2 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 0x11111111 .. 0x66666666
        for (int i = 1; i <= 5; i++) do_op(1'b1, 1'b0, 32'h1111_1111 * i, 16'd0);
        settle();
        check("fill5_full", {31'b0, bus.full}, 32'h0);
        check("fill5_edges", bus.edges, 32'h0);
        do_op(1'b1, 1'b0, 32'h6666_6666, 16'd0);
        settle();
        check("fill6_full", {31'b0, bus.full}, 32'h1);
        check("fill6_w5", bus.w5, 32'h1111_1111);
        check("fill6_w0", bus.w0, 32'h6666_6666);

        // 7th write: oldest word drops out, full stays up
        do_op(1'b1, 1'b0, 32'h7777_7777, 16'd0);
        settle();
        check("ovf_w5", bus.w5, 32'h2222_2222);
        check("ovf_w0", bus.w0, 32'h7777_7777);
        check("ovf_full", {31'b0, bus.full}, 32'h1);

        // Flush together with write: flush wins
        do_op(1'b1, 1'b1, 32'hDEAD_BEEF, 16'd0);
        settle();
        check_all_zero("flush_we");

        // Flat image, threshold 0
        for (int i = 0; i < 6; i++) do_op(1'b1, 1'b0, 32'h8080_8080, 16'd0);
        settle();
        check("flat_full", {31'b0, bus.full}, 32'h1);
        check("flat_edges", bus.edges, 32'h0);

        // Vertical edge
        for (int i = 0; i < 6; i++)
            do_op(1'b1, 1'b0, (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0, 16'd100);
        settle();
        check("vert_thr100", bus.edges, 32'h00FF_FF00);
        do_op(1'b0, 1'b0, 32'h0, 16'd1020);
        settle();
        check("vert_thr1020", bus.edges, VERT_HIGH_THR);
        do_op(1'b0, 1'b0, 32'h0, 16'd1019);
        settle();
        check("vert_thr1019", bus.edges, 32'h00FF_FF00);

        // Randomised traffic with an asynchronous reset in the middle
        random_ops(200);
        mid_reset();
        random_ops(200);
        settle();
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
